imm_decode_pipe: RTL and testbench

//  Elastic, parametrised immediate-generation stage for the RISC-V core front end.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_decode.sv | 54 +++++
 rtl/imm_decode_pipe.sv | 115 +++++++++++
 tb/tb_imm_decode_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants and payload type for the immediate-decode pipeline.
package imm_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned FMT_W  = 6;
    localparam int unsigned OPC_W  = 7;

    // One-hot instruction formats, bit order {J,U,B,S,I,R}
    localparam logic [FMT_W-1:0] FMT_R = 6'b000001;
    localparam logic [FMT_W-1:0] FMT_I = 6'b000010;
    localparam logic [FMT_W-1:0] FMT_S = 6'b000100;
    localparam logic [FMT_W-1:0] FMT_B = 6'b001000;
    localparam logic [FMT_W-1:0] FMT_U = 6'b010000;
    localparam logic [FMT_W-1:0] FMT_J = 6'b100000;

    localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_SYS    = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [FMT_W-1:0]  format;
        logic              illegal;
    } dec_info_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-driven format decode and sign-extended immediate generation.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] i_inst,
    output logic [FMT_W-1:0]  o_format,
    output logic [XLEN-1:0]   o_immediate,
    output logic              o_illegal
);

    logic [INST_W-1:0] imm32;

    always_comb begin
        o_format  = '0;
        o_illegal = 1'b0;
        imm32     = '0;
        case (i_inst[OPC_W-1:0])
            OP_OP: o_format = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYS: begin
                o_format = FMT_I;
                imm32    = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OP_STORE: begin
                o_format = FMT_S;
                imm32    = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OP_BRANCH: begin
                o_format = FMT_B;
                imm32    = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                            i_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                o_format = FMT_U;
                imm32    = {i_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                o_format = FMT_J;
                imm32    = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                            i_inst[30:21], 1'b0};
            end
            default: o_illegal = 1'b1;
        endcase
    end

    // All formats are already sign-extended to 32 bits; widen from bit 31 for RV64
    if (XLEN > INST_W) begin : g_wide
        assign o_immediate = {{(XLEN-INST_W){imm32[INST_W-1]}}, imm32};
    end else begin : g_narrow
        assign o_immediate = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Elastic immediate-generation stage: decode at the input, then DEPTH valid/ready register stages.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [FMT_W-1:0]  o_format,
    output logic [XLEN-1:0]   o_immediate,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_illegal_cnt
);

    logic [FMT_W-1:0] dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    dec_info_t        dec_info;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_inst      (i_inst),
        .o_format    (dec_fmt),
        .o_immediate (dec_imm),
        .o_illegal   (dec_ill)
    );

    assign dec_info = '{inst: i_inst, format: dec_fmt, illegal: dec_ill};

    logic [DEPTH-1:0] v_q;
    logic [DEPTH:0]   rdy;
    dec_info_t        info_q [DEPTH];
    logic [XLEN-1:0]  imm_q  [DEPTH];
    logic             accept;

    // Ready ripples back from the consumer; a stage can take data if empty or draining
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = i_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            rdy[k] = ~v_q[k] | rdy[k+1];
        end
    end

    assign o_ready = rdy[0] & ~i_flush;
    assign accept  = i_valid & o_ready;

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic            in_v;
        dec_info_t       in_info;
        logic [XLEN-1:0] in_imm;
        logic            v_r;
        dec_info_t       info_r;
        logic [XLEN-1:0] imm_r;

        if (k == 0) begin : g_head
            assign in_v    = accept;
            assign in_info = dec_info;
            assign in_imm  = dec_imm;
        end else begin : g_body
            assign in_v    = v_q[k-1];
            assign in_info = info_q[k-1];
            assign in_imm  = imm_q[k-1];
        end

        // Data only moves with a valid entry so an empty stage keeps its contents
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_r    <= 1'b0;
                info_r <= '0;
                imm_r  <= '0;
            end else begin
                if (i_flush) begin
                    v_r <= 1'b0;
                end else if (rdy[k]) begin
                    v_r <= in_v;
                end
                if (rdy[k] && in_v) begin
                    info_r <= in_info;
                    imm_r  <= in_imm;
                end
            end
        end

        assign v_q[k]    = v_r;
        assign info_q[k] = info_r;
        assign imm_q[k]  = imm_r;
    end

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (accept && dec_ill && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_valid       = v_q[DEPTH-1];
    assign o_inst        = info_q[DEPTH-1].inst;
    assign o_format      = info_q[DEPTH-1].format;
    assign o_illegal     = info_q[DEPTH-1].illegal;
    assign o_immediate   = imm_q[DEPTH-1];
    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Randomised and directed bench for imm_decode_pipe against a field-arithmetic reference model.
module tb_imm_decode_pipe;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] I_ADDI  = 32'h07B10093;
    localparam logic [31:0] I_SW    = 32'hFE552623;
    localparam logic [31:0] I_BEQ   = 32'hFE0008E3;
    localparam logic [31:0] I_LUI   = 32'h800000B7;
    localparam logic [31:0] I_JAL   = 32'h001000EF;
    localparam logic [31:0] I_JALN  = 32'hFF1FF06F;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_flush, i_valid, i_ready;
    logic [31:0]       i_inst;
    logic              o_ready, o_valid, o_illegal;
    logic [31:0]       o_inst;
    logic [5:0]        o_format;
    logic [XLEN-1:0]   o_immediate;
    logic [CNT_W-1:0]  o_illegal_cnt;

    imm_decode_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_inst        (i_inst),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_inst        (o_inst),
        .o_format      (o_format),
        .o_immediate   (o_immediate),
        .o_illegal     (o_illegal),
        .o_illegal_cnt (o_illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  fmt;
        logic [63:0] imm;
        logic        ill;
        int          cyc;
    } ent_t;

    ent_t q[$];
    ent_t seen[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, n_acc = 0, mcnt = 0;
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic longint sx(input longint val, input int n);
        return val[n-1] ? val - (longint'(1) << n) : val;
    endfunction

    // Reference decode: immediates rebuilt as signed integers from the ISA field weights
    function automatic ent_t ref_dec(input logic [31:0] inst);
        ent_t   e;
        longint v = 0;
        e.inst = inst; e.fmt = 6'd0; e.ill = 1'b0; e.cyc = 0;
        case (inst[6:0])
            7'h33:                      e.fmt = 6'd1;
            7'h13, 7'h03, 7'h67, 7'h73: begin e.fmt = 6'd2;  v = sx(longint'(inst[31:20]), 12); end
            7'h23: begin
                e.fmt = 6'd4;
                v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
            end
            7'h63: begin
                e.fmt = 6'd8;
                v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                       + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin e.fmt = 6'd16; v = sx(longint'(inst[31:12]) * 4096, 32); end
            7'h6F: begin
                e.fmt = 6'd32;
                v = sx(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                       + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(XLEN'(v));
        return e;
    endfunction

    // One cycle: compare outputs against the in-flight queue, then apply this cycle's handshakes
    task automatic check_cycle();
        logic exp_ready, exp_valid;
        ent_t e, o;
        exp_ready = !i_flush && (q.size() < int'(DEPTH) || i_ready);
        exp_valid = (q.size() > 0) && (q[0].cyc <= cyc);
        chk("o_ready", 64'(o_ready), 64'(exp_ready));
        chk("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("o_inst", 64'(o_inst), 64'(q[0].inst));
            chk("o_format", 64'(o_format), 64'(q[0].fmt));
            chk("o_immediate", 64'(o_immediate), q[0].imm);
            chk("o_illegal", 64'(o_illegal), 64'(q[0].ill));
        end
        chk("o_illegal_cnt", 64'(o_illegal_cnt), 64'(mcnt));
        if (exp_valid && i_ready) begin
            o.inst = o_inst; o.fmt = o_format; o.imm = 64'(o_immediate);
            o.ill = o_illegal; o.cyc = cyc;
            seen.push_back(o);
            void'(q.pop_front());
        end
        if (i_valid && exp_ready) begin
            e = ref_dec(i_inst);
            e.cyc = cyc + int'(DEPTH);
            q.push_back(e);
            n_acc++;
            if (e.ill && mcnt < CNT_MAX) mcnt++;
        end
        if (i_flush) q.delete();
        cyc++;
    endtask

    task automatic tick(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
        @(negedge clk);
        i_valid = v; i_inst = inst; i_ready = rdy; i_flush = fl;
        #1;
        check_cycle();
    endtask

    task automatic seen_is(input string tag, input int idx, input logic [31:0] inst,
                           input logic [5:0] fmt, input logic [63:0] imm);
        if (seen.size() > idx) begin
            chk({tag, "_inst"}, 64'(seen[idx].inst), 64'(inst));
            chk({tag, "_fmt"}, 64'(seen[idx].fmt), 64'(fmt));
            chk({tag, "_imm"}, seen[idx].imm, imm);
        end else begin
            chk({tag, "_present"}, 64'(seen.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int a0;
        logic [31:0] r;
        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_inst = '0;
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_imm", 64'(o_immediate), 64'd0);
        chk("rst_o_inst", 64'(o_inst), 64'd0);
        chk("rst_cnt", 64'(o_illegal_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single ADDI latency
        seen.delete(); a0 = cyc;
        tick(1, I_ADDI, 1, 0);
        repeat (4) tick(0, 0, 1, 0);
        chk("t1_count", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) chk("t1_latency", 64'(seen[0].cyc - a0), 64'(DEPTH));
        seen_is("t1", 0, I_ADDI, 6'b000010, 64'd123);

        // Back-to-back full throughput
        seen.delete();
        tick(1, I_SW, 1, 0); tick(1, I_BEQ, 1, 0); tick(1, I_LUI, 1, 0); tick(1, I_JAL, 1, 0);
        repeat (4) tick(0, 0, 1, 0);
        chk("t2_count", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) chk("t2_spacing", 64'(seen[3].cyc - seen[0].cyc), 64'd3);
        seen_is("t2_sw", 0, I_SW, 6'b000100, 64'hFFFFFFFFFFFFFFEC);
        seen_is("t2_beq", 1, I_BEQ, 6'b001000, 64'hFFFFFFFFFFFFFFF0);
        seen_is("t2_lui", 2, I_LUI, 6'b010000, 64'hFFFFFFFF80000000);
        seen_is("t2_jal", 3, I_JAL, 6'b100000, 64'h0000000000000800);

        // 64-bit sign extension and R format
        seen.delete();
        tick(1, I_JALN, 1, 0); tick(1, I_ADD, 1, 0);
        repeat (3) tick(0, 0, 1, 0);
        seen_is("t3_jal", 0, I_JALN, 6'b100000, 64'hFFFFFFFFFFFFFFF0);
        seen_is("t3_add", 1, I_ADD, 6'b000001, 64'd0);

        // Backpressure: capacity DEPTH, then drain in order
        seen.delete(); a0 = n_acc;
        tick(1, I_SW, 0, 0); tick(1, I_BEQ, 0, 0); tick(1, I_LUI, 0, 0);
        chk("t4_o_ready", 64'(o_ready), 64'd0);
        tick(1, I_LUI, 0, 0);
        chk("t4_accepted", 64'(n_acc - a0), 64'(DEPTH));
        tick(1, I_LUI, 1, 0);
        repeat (5) tick(0, 0, 1, 0);
        chk("t4_count", 64'(seen.size()), 64'd3);
        seen_is("t4_a", 0, I_SW, 6'b000100, 64'hFFFFFFFFFFFFFFEC);
        seen_is("t4_b", 1, I_BEQ, 6'b001000, 64'hFFFFFFFFFFFFFFF0);
        seen_is("t4_c", 2, I_LUI, 6'b010000, 64'hFFFFFFFF80000000);

        // Illegal opcode and saturating counter
        seen.delete();
        tick(1, I_ILL, 1, 0);
        repeat (3) tick(0, 0, 1, 0);
        seen_is("t5_ill", 0, I_ILL, 6'b000000, 64'd0);
        if (seen.size() > 0) chk("t5_illegal", 64'(seen[0].ill), 64'd1);
        chk("t5_cnt1", 64'(o_illegal_cnt), 64'd1);
        repeat (4) tick(1, I_ILL, 1, 0);
        repeat (3) tick(0, 0, 1, 0);
        chk("t5_cnt_sat", 64'(o_illegal_cnt), 64'd3);

        // Flush with two entries in flight
        a0 = n_acc;
        tick(1, I_ADDI, 0, 0); tick(1, I_SW, 0, 0); tick(0, 0, 0, 0);
        tick(1, I_LUI, 0, 1);
        tick(0, 0, 1, 0);
        chk("t6_flush_valid", 64'(o_valid), 64'd0);
        chk("t6_flush_blocked", 64'(n_acc - a0), 64'd2);

        // Asynchronous reset mid-stream
        tick(1, I_ADDI, 0, 0); tick(1, I_BEQ, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0; i_valid = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(o_valid), 64'd0);
        chk("t6_rst_cnt", 64'(o_illegal_cnt), 64'd0);
        chk("t6_rst_imm", 64'(o_immediate), 64'd0);
        q.delete(); mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
            tick(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 99) < 3));
        end
        repeat (6) tick(0, 0, 1, 0);
        chk("final_empty", 64'(o_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
